// File: rtl/i2s_sample_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_sample_rx
// Purpose  : I2S receiver sampled by the system clock; emits one 16-bit signed
//            sample per stereo frame (left, right or their average).
// Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_rx #(
  parameter int CHANNEL   = 0,
  parameter int SLOT_BITS = 32
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               i2s_bclk,
  input  logic               i2s_lrck,
  input  logic               i2s_data,
  input  logic               clr_err,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic               err_flag
);

  localparam int c_CNT_W = $clog2(SLOT_BITS + 1);

  localparam logic [1:0] c_WAIT_EDGE = 2'd0;
  localparam logic [1:0] c_SKIP      = 2'd1;
  localparam logic [1:0] c_SHIFT     = 2'd2;
  localparam logic [1:0] c_DRAIN     = 2'd3;

  logic               r_bclk_s1, r_bclk_s2, r_bclk_prev;
  logic               r_lrck_s1, r_lrck_s2;
  logic               r_data_s1, r_data_s2;
  logic               r_lrck_prev;
  logic               r_primed;
  logic               r_slot_ch;
  logic [c_CNT_W-1:0] r_cnt;
  logic [14:0]        r_shreg;
  logic [15:0]        r_left;
  logic [1:0]         r_state;
  logic [1:0]         w_next_state;

  logic               w_rise;
  logic               w_edge;
  logic               w_clear_word;
  logic               w_shift_en;
  logic               w_word_done;
  logic               w_short;
  logic               w_hit;
  logic [15:0]        w_word;
  logic signed [16:0] w_sum;
  logic [15:0]        w_new_sample;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_bclk_s1   <= 1'b0;
      r_bclk_s2   <= 1'b0;
      r_bclk_prev <= 1'b0;
      r_lrck_s1   <= 1'b0;
      r_lrck_s2   <= 1'b0;
      r_data_s1   <= 1'b0;
      r_data_s2   <= 1'b0;
    end else begin
      r_bclk_s1   <= i2s_bclk;
      r_bclk_s2   <= r_bclk_s1;
      r_bclk_prev <= r_bclk_s2;
      r_lrck_s1   <= i2s_lrck;
      r_lrck_s2   <= r_lrck_s1;
      r_data_s1   <= i2s_data;
      r_data_s2   <= r_data_s1;
    end
  end

  // The first rise after reset only loads lrck_prev, so a reset inside a slot
  // can never be mistaken for a slot boundary.
  assign w_rise = r_bclk_s2 & ~r_bclk_prev;
  assign w_edge = w_rise & r_primed & (r_lrck_s2 != r_lrck_prev);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= c_WAIT_EDGE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_WAIT_EDGE: if (w_edge) w_next_state = c_SKIP;
      c_SKIP:      w_next_state = c_SHIFT;
      c_SHIFT: begin
        if (w_edge) begin
          w_next_state = c_SKIP;
        end else if (w_rise && (r_cnt == c_CNT_W'(15))) begin
          w_next_state = c_DRAIN;
        end
      end
      c_DRAIN:     if (w_edge) w_next_state = c_SKIP;
      default:     w_next_state = c_WAIT_EDGE;
    endcase
  end

  // The rise that reveals the lrck edge carries the one-bit I2S delay and is
  // dropped; SKIP just clears the word before shifting starts.
  always_comb begin
    w_clear_word = 1'b0;
    w_shift_en   = 1'b0;
    w_word_done  = 1'b0;
    w_short      = 1'b0;
    case (r_state)
      c_SKIP:  w_clear_word = 1'b1;
      c_SHIFT: begin
        if (w_edge) begin
          w_short = 1'b1;
        end else if (w_rise) begin
          w_shift_en  = 1'b1;
          w_word_done = (r_cnt == c_CNT_W'(15));
        end
      end
      default: ;
    endcase
  end

  assign w_word       = {r_shreg, r_data_s2};
  assign w_sum        = $signed({r_left[15], r_left}) + $signed({w_word[15], w_word});
  assign w_hit        = (CHANNEL == 0) ? ~r_slot_ch : r_slot_ch;
  assign w_new_sample = (CHANNEL == 2) ? 16'(w_sum >>> 1) : w_word;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_lrck_prev  <= 1'b0;
      r_primed     <= 1'b0;
      r_slot_ch    <= 1'b0;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_left       <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      err_flag     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (w_rise) begin
        r_lrck_prev <= r_lrck_s2;
        r_primed    <= 1'b1;
      end
      if (w_edge) r_slot_ch <= r_lrck_s2;
      if (w_clear_word) begin
        r_cnt   <= '0;
        r_shreg <= '0;
      end else if (w_shift_en) begin
        r_cnt   <= r_cnt + c_CNT_W'(1);
        r_shreg <= w_word[14:0];
      end
      if (w_word_done) begin
        if (!r_slot_ch) r_left <= w_word;
        if (w_hit) begin
          sample       <= w_new_sample;
          sample_valid <= 1'b1;
        end
      end
      if (w_short) begin
        err_flag <= 1'b1;
      end else if (clr_err) begin
        err_flag <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_sample_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2s_sample_rx
// Purpose  : Directed and jittered-frame bench for three receiver configurations
//            (left, right, average) driven from one shared I2S bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_sample_rx;

  logic            clk = 1'b0;
  logic            nreset;
  logic            bclk, lrck, sdata, clr_err;
  logic [2:0][15:0] samp;
  logic [2:0]      vld, errf;

  always #5 clk = ~clk;

  i2s_sample_rx #(.CHANNEL(0), .SLOT_BITS(32)) dut0 (
    .clk(clk), .nreset(nreset), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_data(sdata),
    .clr_err(clr_err), .sample(samp[0]), .sample_valid(vld[0]), .err_flag(errf[0]));
  i2s_sample_rx #(.CHANNEL(1), .SLOT_BITS(24)) dut1 (
    .clk(clk), .nreset(nreset), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_data(sdata),
    .clr_err(clr_err), .sample(samp[1]), .sample_valid(vld[1]), .err_flag(errf[1]));
  i2s_sample_rx #(.CHANNEL(2), .SLOT_BITS(32)) dut2 (
    .clk(clk), .nreset(nreset), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_data(sdata),
    .clr_err(clr_err), .sample(samp[2]), .sample_valid(vld[2]), .err_flag(errf[2]));

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mq [3][$];
  logic [15:0] exp_cur [3];
  int          exp_cnt [3];
  int          got_cnt [3];
  logic [2:0]  pv;
  logic        m_primed, m_lr, m_pend_short, m_err;
  logic [15:0] m_hold;
  bit          jitter = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] avg16(input logic [15:0] l, input logic [15:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return 16'(s >>> 1);
  endfunction

  task automatic model_reset();
    m_primed     = 1'b0;
    m_lr         = 1'b0;
    m_pend_short = 1'b0;
    m_err        = 1'b0;
    m_hold       = '0;
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      exp_cur[k] = '0;
    end
  endtask

  // Slot-level model: a slot opens when its lrck differs from the last one seen;
  // it yields a word when it lasts the edge bit plus 16 data bits.
  task automatic model_slot(input logic lr, input logic [15:0] w, input int nbits);
    if (!m_primed) begin
      m_primed = 1'b1;
      m_lr     = lr;
      return;
    end
    if (lr == m_lr) return;
    m_lr = lr;
    if (m_pend_short) m_err = 1'b1;
    m_pend_short = (nbits < 17);
    if (nbits >= 17) begin
      if (!lr) begin
        mq[0].push_back(w);
        exp_cnt[0]++;
        m_hold = w;
      end else begin
        mq[1].push_back(w);
        exp_cnt[1]++;
        mq[2].push_back(avg16(m_hold, w));
        exp_cnt[2]++;
      end
    end
  endtask

  task automatic bit_out(input logic lr, input logic d);
    int lo, hi;
    lo = jitter ? int'($urandom_range(15, 25)) : 20;
    hi = jitter ? int'($urandom_range(15, 25)) : 20;
    bclk  = 1'b0;
    lrck  = lr;
    sdata = d;
    #(lo);
    bclk  = 1'b1;
    #(hi);
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits);
    model_slot(lr, w, nbits);
    for (int i = 0; i < nbits; i++) begin
      logic d;
      if (i >= 1 && i <= 16) d = w[16-i];
      else                   d = 1'($urandom);
      bit_out(lr, d);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbits);
    send_slot(1'b0, l, nbits);
    send_slot(1'b1, r, nbits);
  endtask

  task automatic settle();
    bclk = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic checkpoint(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s pulses d%0d", tag, k), got_cnt[k], exp_cnt[k]);
      chk($sformatf("%s err d%0d", tag, k), errf[k], m_err);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!nreset) begin
        chk($sformatf("reset sample d%0d", k), samp[k], 16'h0000);
        chk($sformatf("reset valid d%0d", k), vld[k], 1'b0);
        pv[k] = 1'b0;
      end else begin
        chk($sformatf("valid width d%0d", k), pv[k] & vld[k], 1'b0);
        if (vld[k]) begin
          chk($sformatf("pulse expected d%0d", k), mq[k].size() > 0, 1'b1);
          if (mq[k].size() > 0) exp_cur[k] = mq[k].pop_front();
          got_cnt[k]++;
        end
        chk($sformatf("sample d%0d", k), samp[k], exp_cur[k]);
        pv[k] = vld[k];
      end
    end
  end

  initial begin
    int base;
    nreset  = 1'b0;
    bclk    = 1'b0;
    lrck    = 1'b0;
    sdata   = 1'b0;
    clr_err = 1'b0;
    pv      = '0;
    for (int k = 0; k < 3; k++) begin
      exp_cnt[k] = 0;
      got_cnt[k] = 0;
    end
    model_reset();
    repeat (4) @(posedge clk);
    #1 nreset = 1'b1;

    // Lead-in slot only arms edge detection.
    send_slot(1'b1, 16'hDEAD, 32);

    for (int f = 0; f < 3; f++) send_frame(16'h1234, 16'hABCD, 32);
    settle();
    checkpoint("t1");
    chk("t1 left sample", samp[0], 16'h1234);
    chk("t1 right sample", samp[1], 16'hABCD);
    chk("t1 avg sample", samp[2], 16'hDF00);
    chk("t1 left pulses", got_cnt[0], 3);
    chk("t1 err", errf[0], 1'b0);

    send_frame(16'h5555, 16'h8001, 32);
    settle();
    checkpoint("t2");
    chk("t2 right sample", samp[1], 16'h8001);
    chk("t2 left sample", samp[0], 16'h5555);
    chk("t2 avg sample", samp[2], 16'hEAAB);

    send_frame(16'h7FFF, 16'h7FFF, 32);
    settle();
    chk("t3 avg max", samp[2], 16'h7FFF);
    send_frame(16'h8000, 16'h7FFF, 32);
    settle();
    chk("t3 avg neg", samp[2], 16'hFFFF);
    send_frame(16'h0003, 16'h0001, 32);
    settle();
    chk("t3 avg small", samp[2], 16'h0002);
    checkpoint("t3");

    send_slot(1'b0, 16'h1111, 11);
    send_slot(1'b1, 16'h2222, 24);
    settle();
    checkpoint("t4a");
    chk("t4 err set", errf[0], 1'b1);
    chk("t4 left held", samp[0], 16'h0003);
    chk("t4 right after short", samp[1], 16'h2222);
    chk("t4 stale avg", samp[2], 16'h1112);
    send_frame(16'h0100, 16'h0300, 24);
    settle();
    checkpoint("t4b");
    chk("t4 left recovers", samp[0], 16'h0100);
    chk("t4 avg recovers", samp[2], 16'h0200);
    chk("t4 err sticky", errf[2], 1'b1);
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    m_err = 1'b0;
    settle();
    checkpoint("t4c");
    chk("t4 err cleared", errf[1], 1'b0);

    for (int i = 0; i < 9; i++) bit_out(1'b0, (i >= 1) ? 1'b1 : 1'b0);
    bclk = 1'b0;
    #7 nreset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5 async sample d%0d", k), samp[k], 16'h0000);
      chk($sformatf("t5 async valid d%0d", k), vld[k], 1'b0);
    end
    repeat (4) @(posedge clk);
    #1 nreset = 1'b1;
    send_slot(1'b0, 16'h4444, 23);
    send_slot(1'b1, 16'h0600, 32);
    settle();
    checkpoint("t5a");
    chk("t5 no left yet", samp[0], 16'h0000);
    chk("t5 right", samp[1], 16'h0600);
    chk("t5 avg fresh hold", samp[2], 16'h0300);
    send_frame(16'h0700, 16'h0900, 32);
    settle();
    checkpoint("t5b");
    chk("t5 left", samp[0], 16'h0700);
    chk("t5 avg", samp[2], 16'h0800);

    jitter = 1'b1;
    base   = got_cnt[2];
    for (int f = 0; f < 100; f++) begin
      send_frame(16'($urandom), 16'($urandom), int'($urandom_range(18, 32)));
    end
    settle();
    checkpoint("t6");
    chk("t6 frame count", got_cnt[2] - base, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
